// File: rtl/wave_sequencer.sv
// Command-driven DDS sequencer: parses SPI command frames and drives an 8-bit DAC bus.
// Define WAVE_SEQUENCER_SINE_EN to add a quarter-wave sine ROM on shape 2'b11.

module wave_sequencer #(
  parameter int unsigned ACC_W     = 24,
  parameter logic [15:0] TW_RESET  = 16'h0100,
  parameter logic [7:0]  AMP_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  input  logic       cmd_abort,
  output logic [7:0] dac_out,
  output logic       busy,
  output logic       cmd_err,
  output logic       manual
);

  typedef enum logic [2:0] {StIdle, StFreqHi, StFreqLo, StAmpD, StDirectD} state_e;

  state_e           state_q, state_d;
  logic [7:0]       stage_q, stage_d;
  logic [15:0]      tw_q, tw_d;
  logic [7:0]       amp_q, amp_d;
  logic [1:0]       shape_q, shape_d;
  logic             manual_q, manual_d;
  logic [7:0]       direct_q, direct_d;
  logic             err_d;
  logic             run;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       dac_q, dac_d;
  logic [7:0]       phase;
  logic [7:0]       sample;
  logic [8:0]       amp_p1;
  logic [15:0]      prod;

  // Command parser: abort wins over a same-cycle byte and leaves configuration untouched.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    tw_d     = tw_q;
    amp_d    = amp_q;
    shape_d  = shape_q;
    manual_d = manual_q;
    direct_d = direct_q;
    err_d    = 1'b0;
    run      = 1'b0;
    if (cmd_abort) begin
      state_d = StIdle;
    end else if (cmd_valid) begin
      unique case (state_q)
        StIdle: begin
          case (cmd_byte[7:5])
            3'b001:         shape_d = cmd_byte[1:0];
            3'b010:         state_d = StFreqHi;
            3'b011:         state_d = StAmpD;
            3'b100:         state_d = StDirectD;
            3'b101: begin
              manual_d = 1'b0;
              run      = 1'b1;
            end
            3'b110, 3'b111: err_d = 1'b1;
            default: ;
          endcase
        end
        StFreqHi: begin
          stage_d = cmd_byte;
          state_d = StFreqLo;
        end
        StFreqLo: begin
          tw_d    = {stage_q, cmd_byte};
          state_d = StIdle;
        end
        StAmpD: begin
          amp_d   = cmd_byte;
          state_d = StIdle;
        end
        StDirectD: begin
          direct_d = cmd_byte;
          manual_d = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    if (run) begin
      acc_d = '0;
    end else if (manual_q) begin
      acc_d = acc_q;
    end else begin
      acc_d = acc_q + ACC_W'(tw_q);
    end
  end

  assign phase = acc_q[ACC_W-1 -: 8];

`ifdef WAVE_SEQUENCER_SINE_EN
  // round(127 * sin(pi/2 * i/64)), i = 0..63
  localparam logic [6:0] SineRom [64] = '{
    0,   3,   6,   9,   12,  16,  19,  22,
    25,  28,  31,  34,  37,  40,  43,  46,
    49,  51,  54,  57,  60,  63,  65,  68,
    71,  73,  76,  78,  81,  83,  85,  88,
    90,  92,  94,  96,  98,  100, 102, 104,
    106, 107, 109, 111, 112, 113, 115, 116,
    117, 118, 120, 121, 122, 122, 123, 124,
    125, 125, 126, 126, 126, 127, 127, 127
  };

  logic [5:0] rom_addr;
  logic [7:0] rom_entry;
  logic [7:0] sine_sample;

  always_comb begin
    rom_addr    = phase[6] ? ~phase[5:0] : phase[5:0];
    rom_entry   = {1'b0, SineRom[rom_addr]};
    sine_sample = phase[7] ? (8'h80 - rom_entry) : (8'h80 + rom_entry);
  end
`endif

  always_comb begin
    case (shape_q)
      2'b01:   sample = phase[7] ? 8'hFF : 8'h00;
      2'b10:   sample = phase;
`ifdef WAVE_SEQUENCER_SINE_EN
      2'b11:   sample = sine_sample;
`else
      2'b11:   sample = 8'h00;
`endif
      default: sample = 8'h00;
    endcase
  end

  // amp + 1 makes amp=FF an exact pass-through and amp=00 collapse to zero.
  always_comb begin
    amp_p1 = {1'b0, amp_q} + 9'd1;
    prod   = {8'h00, sample} * {7'h00, amp_p1};
    dac_d  = manual_q ? direct_q : prod[15:8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      stage_q  <= 8'h00;
      tw_q     <= TW_RESET;
      amp_q    <= AMP_RESET;
      shape_q  <= 2'b00;
      manual_q <= 1'b0;
      direct_q <= 8'h00;
      cmd_err  <= 1'b0;
      acc_q    <= '0;
      dac_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      tw_q     <= tw_d;
      amp_q    <= amp_d;
      shape_q  <= shape_d;
      manual_q <= manual_d;
      direct_q <= direct_d;
      cmd_err  <= err_d;
      acc_q    <= acc_d;
      dac_q    <= dac_d;
    end
  end

  assign dac_out = dac_q;
  assign busy    = (state_q != StIdle);
  assign manual  = manual_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer: frame-level reference model checked every cycle, plus
// directed literal checks and randomized command traffic.

module tb_wave_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_abort = 1'b0;
  logic [7:0] dac_out;
  logic       busy;
  logic       cmd_err;
  logic       manual;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  wave_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_byte  (cmd_byte),
    .cmd_valid (cmd_valid),
    .cmd_abort (cmd_abort),
    .dac_out   (dac_out),
    .busy      (busy),
    .cmd_err   (cmd_err),
    .manual    (manual)
  );

  always #5 clk = ~clk;

  // Reference model state (24-bit accumulator).
  int unsigned m_acc, m_tw, m_amp, m_direct, m_dac, m_need, m_op;
  logic [1:0]  m_shape;
  bit          m_manual, m_err;
  logic [7:0]  m_data[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned model_sample(input int unsigned acc, input logic [1:0] shp);
    int unsigned p;
    p = (acc >> 16) & 255;
    case (shp)
      2'd1: return (p >= 128) ? 255 : 0;
      2'd2: return p;
`ifdef WAVE_SEQUENCER_SINE_EN
      2'd3: begin
        int unsigned idx, q, e;
        idx = p % 64;
        q   = p / 64;
        if (q % 2 == 1) idx = 63 - idx;
        e = $rtoi(127.0 * $sin(3.14159265358979 / 2.0 * real'(idx) / 64.0) + 0.5);
        return (q >= 2) ? 128 - e : 128 + e;
      end
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_tw = 16'h0100; m_amp = 8'hFF; m_direct = 0; m_dac = 0;
    m_shape = 2'b00; m_manual = 0; m_err = 0; m_need = 0; m_op = 0;
    m_data.delete();
  endtask

  task automatic model_step();
    int unsigned nd, na;
    bit err;
    err = 0;
    nd = m_manual ? m_direct : (model_sample(m_acc, m_shape) * (m_amp + 1)) / 256;
    na = m_manual ? m_acc : (m_acc + m_tw) % (1 << 24);
    if (cmd_abort) begin
      m_need = 0;
      m_data.delete();
    end else if (cmd_valid) begin
      if (m_need == 0) begin
        case (cmd_byte[7:5])
          3'd1: m_shape = cmd_byte[1:0];
          3'd2: begin m_op = 2; m_need = 2; end
          3'd3: begin m_op = 3; m_need = 1; end
          3'd4: begin m_op = 4; m_need = 1; end
          3'd5: begin m_manual = 0; na = 0; end
          3'd6, 3'd7: err = 1;
          default: ;
        endcase
      end else begin
        m_data.push_back(cmd_byte);
        if (m_data.size() == int'(m_need)) begin
          case (m_op)
            2: m_tw = {m_data[0], m_data[1]};
            3: m_amp = m_data[0];
            4: begin m_direct = m_data[0]; m_manual = 1; end
            default: ;
          endcase
          m_need = 0;
          m_data.delete();
        end
      end
    end
    m_acc = na;
    m_dac = nd;
    m_err = err;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("dac_out", dac_out, m_dac);
        check("busy", busy, (m_need != 0));
        check("cmd_err", cmd_err, m_err);
        check("manual", manual, m_manual);
      end
    end
  end

  // Present one byte for one cycle, then idle for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    cmd_byte  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic abort_now();
    cmd_abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_byte  = 8'hCD;
    @(negedge clk);
    cmd_abort = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_dac", dac_out, 8'h00);
    check("reset_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Saw at tw=1234 from acc=0
    send(8'h40, 0); send(8'h12, 0); send(8'h34, 1);
    check("model_tw_1234", m_tw, 16'h1234);
    send(8'h22, 0);
    send(8'hA0, 0);
    @(negedge clk);
    check("saw_m1", dac_out, 8'h00);
    repeat (15) @(negedge clk);
    check("saw_m16", dac_out, 8'h01);
    repeat (40) @(negedge clk);

    // Reset in the middle of a FREQ frame
    send(8'h40, 0); send(8'h12, 0);
    #3 rst = 1'b0;
    #1;
    check("rst_dac", dac_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", cmd_err, 1'b0);
    check("rst_manual", manual, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    check("model_tw_reset", m_tw, 16'h0100);
    send(8'h22, 0);
    repeat (255) @(negedge clk);
    check("post_rst_p0", dac_out, 8'h00);
    @(negedge clk);
    check("post_rst_p1", dac_out, 8'h01);

    // Abort discards a partial FREQ frame
    send(8'h40, 0); send(8'hAB, 0);
    abort_now();
    check("abort_busy", busy, 1'b0);
    send(8'h40, 0); send(8'h00, 0); send(8'h10, 2);
    check("model_tw_0010", m_tw, 16'h0010);

    // Square with amplitude 80, then 00
    send(8'h40, 0); send(8'h80, 0); send(8'h00, 0);
    send(8'h21, 0); send(8'h60, 0); send(8'h80, 0);
    send(8'hA0, 0);
    repeat (10) @(negedge clk);
    check("sq_low", dac_out, 8'h00);
    repeat (290) @(negedge clk);
    check("sq_high_amp80", dac_out, 8'h80);
    send(8'h60, 0); send(8'h00, 4);
    check("sq_high_amp00", dac_out, 8'h00);

    // Direct write and RUN
    send(8'h60, 0); send(8'hFF, 0);
    send(8'h80, 0); send(8'h5A, 0);
    check("direct_manual", manual, 1'b1);
    @(negedge clk);
    check("direct_dac", dac_out, 8'h5A);
    repeat (5) @(negedge clk);
    check("direct_hold", dac_out, 8'h5A);
    send(8'hA0, 0);
    check("run_manual", manual, 1'b0);
    repeat (8) @(negedge clk);

    // Invalid opcode
    send(8'hE3, 0);
    check("err_pulse", cmd_err, 1'b1);
    check("err_busy", busy, 1'b0);
    @(negedge clk);
    check("err_clear", cmd_err, 1'b0);

`ifdef WAVE_SEQUENCER_SINE_EN
    send(8'h23, 0); send(8'h40, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'hA0, 0);
    repeat (2) @(negedge clk);
    check("sine_phase0", dac_out, 8'h80);
`endif

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0: send({3'b000, 5'($urandom)}, $urandom_range(0, 2));
        1: send({6'b001000, 2'($urandom)}, $urandom_range(0, 2));
        2: begin
          send(8'h40, $urandom_range(0, 1));
          send(8'($urandom), $urandom_range(0, 1));
          send(8'($urandom), $urandom_range(0, 2));
        end
        3: begin send(8'h60, $urandom_range(0, 1)); send(8'($urandom), $urandom_range(0, 2)); end
        4: begin send(8'h80, $urandom_range(0, 1)); send(8'($urandom), $urandom_range(0, 2)); end
        5: send(8'hA0, $urandom_range(0, 2));
        6: send({2'b11, 6'($urandom)}, $urandom_range(0, 2));
        7: begin
          send({3'($urandom_range(2, 4)), 5'h00}, $urandom_range(0, 1));
          abort_now();
        end
        8: repeat ($urandom_range(0, 20)) @(negedge clk);
        default: send(8'($urandom), $urandom_range(0, 2));
      endcase
    end
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Command-driven DDS sequencer between the SPI client's decoded byte stream and the 8-bit parallel DAC bus (D7..D0).
- Parses multi-byte command frames, holds waveform configuration (shape, tuning word, amplitude) and drives the DAC every clock from a phase accumulator.
- Also provides a manual mode that writes raw DAC codes directly.

Parameters:
- ACC_W, 24, phase accumulator width; phase index is acc[ACC_W-1 -: 8]; must be >= 16.
- TW_RESET, 16'h0100, tuning word loaded at reset.
- AMP_RESET, 8'hFF, amplitude loaded at reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- cmd_byte  input  8  received command/data byte.
- cmd_valid  input  1  one-cycle strobe; cmd_byte valid this cycle.
- cmd_abort  input  1  chip-select deassert; terminates any partial frame.
- dac_out  output  8  registered DAC code.
- busy  output  1  high while the parser is mid-frame (awaiting data bytes).
- cmd_err  output  1  one-cycle pulse on an invalid opcode.
- manual  output  1  high while in direct-write mode.

Behaviour:
- Reset (rst=0, async) values:
  - dac_out=8'h00, busy=0, cmd_err=0, manual=0.
  - acc=0, shape=2'b00 (off), tw=TW_RESET, amp=AMP_RESET, parser=IDLE.
- Header byte opcode is cmd_byte[7:5]:
  - 000 NOP.
  - 001 SHAPE: shape<=cmd_byte[1:0]; 00 off, 01 square, 10 sawtooth, 11 see optional feature.
  - 010 FREQ: two data bytes follow, tw[15:8] then tw[7:0].
  - 011 AMP: one data byte follows.
  - 100 DIRECT: one data byte follows; sets manual=1 and writes the raw code.
  - 101 RUN: manual<=0, acc<=0.
  - 110, 111: invalid; cmd_err pulses for 1 cycle; parser stays IDLE.
- Parser FSM states: IDLE, FREQ_HI, FREQ_LO, AMP_D, DIRECT_D.
  - Each cmd_valid advances exactly one state; busy=1 in every state except IDLE.
  - FREQ_HI latches the byte into a staging register. In FREQ_LO, tw updates atomically to {stage, byte} on the cycle after the FREQ_LO byte is accepted; a half-written tw is never used.
  - AMP_D: amp<=byte, then IDLE.
  - DIRECT_D: direct code<=byte, manual<=1, then IDLE.
  - cmd_abort has priority over cmd_valid in the same cycle: the parser returns to IDLE, staged data is discarded, and configuration is unchanged.
- Accumulator:
  - acc <= acc + zero-extended tw every clock, modulo 2^ACC_W (wraps silently).
  - Frozen while manual=1.
  - tw=0 holds the phase constant.
- Sample generation, with p = acc[ACC_W-1 -: 8]:
  - square = p[7] ? 8'hFF : 8'h00.
  - saw = p.
  - off = 8'h00.
- Scaling: dac_out <= (sample * (amp + 1)) >> 8, computed in 16 bits with a 9-bit multiplier operand.
  - amp=FF gives an exact pass-through.
  - amp=00 gives sample>>8, i.e. 0.
- Manual mode: dac_out <= direct code, unscaled.
- Latency: dac_out reflects the acc value of the previous cycle (1 register stage). A SHAPE or AMP change is visible on dac_out 2 cycles after its cmd_valid.
- A second DIRECT while already manual simply overwrites the code.
- RUN while not manual only resets acc.

Optional Feature:
- Macro: WAVE_SEQUENCER_SINE_EN.
- Defined: shape 11 selects sine from a 64-entry quarter-wave ROM.
  - Address: p[5:0], mirrored when p[6]=1.
  - Output: 8'h80 ± entry, negated when p[7]=1.
  - Sample is unsigned offset binary, 8'h80 at phase 0; scaling and latency are identical to the other shapes.
- Undefined: shape 11 behaves as off (8'h00); no ROM is instantiated.

Test Plan:
- Reset: rst low mid-FREQ frame → all outputs 0, busy=0, tw=0100 after release, and the accumulator starts from 0.
- FREQ: bytes 40,12,34 then SHAPE 22 (saw) → tw=1234; acc increments by 0x1234 per clk; dac_out tracks acc[23:16] one cycle later.
- Abort: 40,AB, cmd_abort, then 40,00,10 → tw=0010, never 00AB, and busy is low after the abort.
- Amplitude: SHAPE 21 (square), AMP 60,80 → high phase gives dac_out=80, low phase gives 00; with AMP 60,00 both phases give 00.
- Direct/run: 80,5A → manual=1, dac_out=5A with acc frozen; A0 → manual=0, acc=0, and output resumes the configured shape.
- Error: header E3 → cmd_err high for exactly 1 cycle, busy=0, and no configuration change; with the SINE macro, SHAPE 23 at acc=0 gives dac_out=80 when amp=FF.
